rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Eight-requester round-robin arbiter that drives the 8-to-3 encoder stage directly downstream.
- Produces a registered one-hot grant vector GNT; the encoder turns it into the winning requester's index.
- GNT is guaranteed one-hot or all-zero, so the encoder never sees a multi-bit input.
- Holds a grant until the owner signals completion or drops its request, then rotates priority.

Parameters:
- N, 8, number of requesters. Fixed at 8 to match the encoder input width; other values are unsupported.
- MAX_HOLD, 15, maximum grant duration in cycles. Used only when TIMEOUT_EN is defined.
- CW, 4, hold-counter width. Must satisfy 2^CW > MAX_HOLD.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  8  request lines; bit i is requester i. Level-sensitive.
- DONE  input  1  one-cycle pulse from the current owner releasing its grant.
- GNT  output  8  registered one-hot grant, or 8'b00000000 when nothing is granted. Feeds encoder input A.
- VALID  output  1  high exactly when GNT is non-zero.
- TIMEOUT  output  1  one-cycle pulse on forced release. Present only with TIMEOUT_EN.

Behaviour:
- Reset, sampled on a CLK edge with RST=1:
  - GNT=0, VALID=0, TIMEOUT=0.
  - State IDLE.
  - Priority pointer PTR=0, so bit 0 has highest priority.
  - Hold counter=0.
- RST dominates every other input. Reset mid-grant clears GNT on the same edge, with no bubble and no DONE required.
- State IDLE:
  - If REQ==0, stay in IDLE with GNT=0.
  - Otherwise, on the next edge, select the first set bit of REQ scanning PTR, PTR+1, ... 7, 0, ... PTR-1.
  - Set GNT to that bit's one-hot value and VALID=1, record the index as OWN, and go to GRANT.
  - REQ-to-GNT latency is 1 cycle.
- State GRANT:
  - GNT is held stable regardless of other REQ changes.
  - Release condition, sampled each edge: DONE==1 or REQ[OWN]==0.
  - On release:
    - GNT=0 and VALID=0 on the next edge.
    - PTR=(OWN+1) mod 8; index 7 wraps to 0.
    - Go to BUBBLE.
- State BUBBLE:
  - Lasts exactly one cycle with GNT=0, then returns to IDLE unconditionally.
  - Arbitration resumes from IDLE, so the earliest re-grant is 2 cycles after the release edge.
  - Guarantees the encoder downstream sees an all-zero gap between grants.
- DONE handling:
  - DONE in IDLE or BUBBLE is ignored.
  - DONE together with a new request in GRANT: release wins; the new request is arbitrated after BUBBLE.
- Fairness: any continuously asserted requester is granted within 7 intervening grants.
- GNT and VALID are never both asserted for different owners; no combinational path from REQ to GNT.

Optional Feature:
- Macro: TIMEOUT_EN.
- Defined:
  - Hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When the counter reaches MAX_HOLD without a release, the next edge forces a release exactly as for DONE.
  - That edge also drives TIMEOUT=1 for one cycle, and PTR advances past OWN.
  - A normal release on the same cycle the counter reaches MAX_HOLD takes precedence, and TIMEOUT stays 0.
- Not defined:
  - No counter and no TIMEOUT port.
  - A grant is held indefinitely until DONE or the request drops.

Test Plan:
- Reset then idle: RST=1 for 2 cycles with REQ=8'b11111111, then REQ=0 → GNT=0 and VALID=0 throughout, including the cycles during reset.
- Basic grant/rotate:
  - REQ=8'b00000101 → GNT=8'b00000001 one cycle later.
  - DONE pulse → GNT=0 for 2 cycles (release + BUBBLE) → GNT=8'b00000100.
  - Second DONE → GNT=8'b00000001 (PTR=3 wraps to bit 0).
- Wrap-around:
  - Grant bit 7 via REQ=8'b10000000, then DONE with REQ=8'b10000010.
  - Next grant is GNT=8'b00000010, proving PTR=0 after index 7, not bit 7 again.
- Request drop and simultaneity:
  - Owner bit 3 drops REQ[3] while DONE=0 → release with identical timing to DONE.
  - DONE coinciding with REQ[5] rising → release, BUBBLE, then GNT=8'b00100000.
- Reset mid-grant: GNT=8'b00010000, RST=1 for one cycle → GNT=0 on that edge; after reset, REQ=8'b00010001 → GNT=8'b00000001.
- TIMEOUT_EN with MAX_HOLD=15:
  - Grant bit 2 and withhold DONE → release edge 16 cycles after the grant edge.
  - TIMEOUT=1 for exactly one cycle on that edge.
  - Next owner is bit 3 if requesting.
  - Without the macro, GNT stays held beyond 100 cycles.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// Eight-requester round-robin arbiter with a registered one-hot grant for the downstream 8-to-3 encoder.
// Latency: REQ to GNT is 1 cycle. After a release there is one all-zero BUBBLE cycle, so the earliest re-grant is 2 cycles later.
// Backpressure: none. The owner keeps the grant until DONE or until it drops its REQ line.
//
// Ports:
//   CLK      system clock; all state updates on the rising edge
//   RST      synchronous, active-high reset; dominates every other input
//   REQ[N]   level-sensitive request lines, bit i = requester i
//   DONE     one-cycle release pulse from the current owner (ignored outside GRANT)
//   GNT[N]   registered one-hot grant, or all-zero when nothing is granted
//   VALID    high exactly when GNT is non-zero
//   TIMEOUT  one-cycle pulse on a forced release (only with TIMEOUT_EN)
//
// Build option: define TIMEOUT_EN to add the hold counter, the MAX_HOLD/CW
// parameters and the TIMEOUT port. Without it, a grant is held indefinitely.

module rr_grant_arbiter #(
    parameter int N = 8
`ifdef TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 15,
    parameter int CW       = 4
`endif
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] REQ,
    input  logic         DONE,
    output logic [N-1:0] GNT,
    output logic         VALID
`ifdef TIMEOUT_EN
    ,
    output logic         TIMEOUT
`endif
);

    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_BUBBLE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] own_q, own_d;
    logic [N-1:0]  gnt_d;
    logic          valid_d;

    logic          pick_vld;
    logic [PW-1:0] pick_idx;
    logic          rel_normal;
    logic          release_now;

`ifdef TIMEOUT_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_d;
    logic          tmo_hit;
`endif

    // Rotating priority scan. The first set bit at or after ptr_q wins. The
    // index sum is PW bits wide, so it wraps from 7 back to 0 on its own.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        for (int k = 0; k < N; k++) begin
            if (!pick_vld && REQ[ptr_q + PW'(k)]) begin
                pick_vld = 1'b1;
                pick_idx = ptr_q + PW'(k);
            end
        end
    end

    // The owner releases by pulsing DONE or by dropping its own request line.
    assign rel_normal = DONE || !REQ[own_q];

`ifdef TIMEOUT_EN
    // The counter reads MAX_HOLD on the cycle before the forced release edge.
    // That edge is therefore MAX_HOLD+1 edges after the grant edge.
    assign tmo_hit     = (state_q == S_GRANT) && (cnt_q == CW'(MAX_HOLD));
    assign release_now = rel_normal || tmo_hit;
`else
    assign release_now = rel_normal;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        gnt_d   = GNT;
        valid_d = VALID;
`ifdef TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_GRANT;
                    own_d   = pick_idx;
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    valid_d = 1'b1;
`ifdef TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            S_GRANT: begin
                // GNT stays frozen here. Other requesters' REQ changes are ignored.
                if (release_now) begin
                    state_d = S_BUBBLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = own_q + PW'(1);
`ifdef TIMEOUT_EN
                    // A normal release on the same edge takes precedence, so no pulse.
                    tmo_d   = tmo_hit && !rel_normal;
`endif
                end
`ifdef TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            S_BUBBLE: begin
                // This guaranteed all-zero cycle separates consecutive grants at the encoder.
                state_d = S_IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            GNT     <= '0;
            VALID   <= 1'b0;
`ifdef TIMEOUT_EN
            cnt_q   <= '0;
            TIMEOUT <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            GNT     <= gnt_d;
            VALID   <= valid_d;
`ifdef TIMEOUT_EN
            cnt_q   <= cnt_d;
            TIMEOUT <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: a table of per-cycle vectors plus hand-written hold/timeout sequences.
// Each vector's expected outputs are queued when its inputs are driven, then popped and compared #1 after the clock edge.
// Build with or without TIMEOUT_EN; the hold sequence adapts to the build.

module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       valid;
`ifdef TIMEOUT_EN
    logic       timeout;
`endif

    always #5 clk = ~clk;

    rr_grant_arbiter dut (
        .CLK   (clk),
        .RST   (rst),
        .REQ   (req),
        .DONE  (done),
        .GNT   (gnt),
        .VALID (valid)
`ifdef TIMEOUT_EN
        ,
        .TIMEOUT (timeout)
`endif
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic       vld;
    } vec_t;

    typedef struct {
        logic [7:0] gnt;
        logic       vld;
        logic       to;
        int         tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic add(input logic r, input logic [7:0] rq, input logic d,
                       input logic [7:0] g, input logic v);
        vec_t x;
        x.rst = r; x.req = rq; x.done = d; x.gnt = g; x.vld = v;
        tbl.push_back(x);
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the next
    // edge, then pop that entry and compare it against the DUT.
    task automatic step(input logic r, input logic [7:0] rq, input logic d,
                        input logic [7:0] eg, input logic ev, input logic et,
                        input int tag);
        exp_t e;
        logic bad;
        rst  = r;
        req  = rq;
        done = d;
        e.gnt = eg; e.vld = ev; e.to = et; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors++;
        bad = (gnt !== e.gnt) || (valid !== e.vld);
`ifdef TIMEOUT_EN
        bad = bad || (timeout !== e.to);
        if (bad)
            $display("FAIL vec %0d: got GNT=%b VALID=%b TIMEOUT=%b, want GNT=%b VALID=%b TIMEOUT=%b",
                     e.tag, gnt, valid, timeout, e.gnt, e.vld, e.to);
`else
        if (bad)
            $display("FAIL vec %0d: got GNT=%b VALID=%b, want GNT=%b VALID=%b (TIMEOUT want %b)",
                     e.tag, gnt, valid, e.gnt, e.vld, e.to);
`endif
        if (bad) miscompares++;
    endtask

    initial begin
        // Reset with every request asserted, then idle.
        add(1, 8'hFF, 0, 8'h00, 0);   // 0
        add(1, 8'hFF, 0, 8'h00, 0);   // 1
        add(0, 8'h00, 0, 8'h00, 0);   // 2
        add(0, 8'h00, 0, 8'h00, 0);   // 3
        // Basic grant and rotate, PTR=0.
        add(0, 8'h05, 0, 8'h01, 1);   // 4  grant bit0
        add(0, 8'h05, 0, 8'h01, 1);   // 5  held
        add(0, 8'h05, 1, 8'h00, 0);   // 6  DONE release, PTR=1
        add(0, 8'h05, 0, 8'h00, 0);   // 7  bubble
        add(0, 8'h05, 0, 8'h04, 1);   // 8  bit2
        add(0, 8'h05, 1, 8'h00, 0);   // 9  release, PTR=3
        add(0, 8'h05, 0, 8'h00, 0);   // 10
        add(0, 8'h05, 0, 8'h01, 1);   // 11 wraps to bit0
        // Owner drops its request, then the wrap past index 7.
        add(0, 8'h00, 0, 8'h00, 0);   // 12 drop release, PTR=1
        add(0, 8'h80, 0, 8'h00, 0);   // 13 bubble
        add(0, 8'h80, 0, 8'h80, 1);   // 14 bit7
        add(0, 8'h82, 1, 8'h00, 0);   // 15 release, PTR=0
        add(0, 8'h82, 0, 8'h00, 0);   // 16
        add(0, 8'h82, 0, 8'h02, 1);   // 17 bit1, not bit7
        add(0, 8'h08, 0, 8'h00, 0);   // 18 bit1 drops, PTR=2
        add(0, 8'h08, 0, 8'h00, 0);   // 19
        add(0, 8'h08, 0, 8'h08, 1);   // 20 bit3
        add(0, 8'h08, 0, 8'h08, 1);   // 21
        add(0, 8'h00, 0, 8'h00, 0);   // 22 bit3 drops with DONE=0, PTR=4
        add(0, 8'h00, 0, 8'h00, 0);   // 23
        add(0, 8'h00, 0, 8'h00, 0);   // 24
        // DONE coinciding with a new request.
        add(0, 8'h01, 0, 8'h01, 1);   // 25 scan from 4 wraps to bit0
        add(0, 8'h21, 1, 8'h00, 0);   // 26 release wins, PTR=1
        add(0, 8'h21, 0, 8'h00, 0);   // 27 bubble
        add(0, 8'h21, 0, 8'h20, 1);   // 28 bit5
        add(0, 8'hFF, 0, 8'h20, 1);   // 29 held despite other requests
        add(0, 8'hDF, 0, 8'h00, 0);   // 30 bit5 drops, PTR=6
        add(0, 8'h10, 0, 8'h00, 0);   // 31
        add(0, 8'h10, 0, 8'h10, 1);   // 32 bit4
        // Reset mid-grant.
        add(1, 8'h10, 0, 8'h00, 0);   // 33 cleared on the same edge
        add(0, 8'h11, 0, 8'h01, 1);   // 34 PTR back to 0, no bubble
        add(0, 8'h11, 1, 8'h00, 0);   // 35 PTR=1
        add(0, 8'h11, 0, 8'h00, 0);   // 36
        add(0, 8'h11, 0, 8'h10, 1);   // 37 bit4
        add(1, 8'h00, 0, 8'h00, 0);   // 38
        // DONE outside GRANT is ignored.
        add(0, 8'h00, 1, 8'h00, 0);   // 39 idle
        add(0, 8'h02, 1, 8'h02, 1);   // 40 grant despite DONE
        add(0, 8'h02, 0, 8'h02, 1);   // 41
        add(0, 8'h02, 1, 8'h00, 0);   // 42 PTR=2
        add(0, 8'h00, 1, 8'h00, 0);   // 43 bubble
        add(0, 8'h00, 0, 8'h00, 0);   // 44

        foreach (tbl[i])
            step(tbl[i].rst, tbl[i].req, tbl[i].done, tbl[i].gnt, tbl[i].vld, 1'b0, i);

        // PTR=2 here: request bits 2 and 3 and withhold DONE.
        step(0, 8'h04, 0, 8'h04, 1, 0, 100);
`ifdef TIMEOUT_EN
        for (int k = 1; k <= 15; k++)
            step(0, 8'h0C, 0, 8'h04, 1, 0, 100 + k);
        step(0, 8'h0C, 0, 8'h00, 0, 1, 116);   // forced release 16 edges after the grant
        step(0, 8'h0C, 0, 8'h00, 0, 0, 117);   // pulse lasts one cycle
        step(0, 8'h0C, 0, 8'h08, 1, 0, 118);   // PTR advanced past bit2
        for (int k = 1; k <= 15; k++)
            step(0, 8'h0C, 0, 8'h08, 1, 0, 200 + k);
        step(0, 8'h0C, 1, 8'h00, 0, 0, 216);   // DONE on the limit cycle: no TIMEOUT
        step(0, 8'h00, 0, 8'h00, 0, 0, 217);
        step(0, 8'h00, 0, 8'h00, 0, 0, 218);
`else
        for (int k = 1; k <= 110; k++)
            step(0, 8'h0C, 0, 8'h04, 1, 0, 100 + k);
        step(0, 8'h0C, 1, 8'h00, 0, 0, 300);
        step(0, 8'h0C, 0, 8'h00, 0, 0, 301);
        step(0, 8'h0C, 0, 8'h08, 1, 0, 302);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
